// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: two-entry elastic buffer (head + skid) carrying the
// EX results into MEM, with branch/jump redirect decode and a stall counter.
module ex_mem_pipe #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RW  = 5,
  parameter int unsigned WBW = 2,
  parameter int unsigned CW  = 16
) (
  input  logic           clkEXMEM,
  input  logic           rstEXMEM,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WBW-1:0] WB2,
  input  logic [2:0]     M2,
  input  logic [DW-1:0]  fAddR,
  input  logic           ZF,
  input  logic [DW-1:0]  fALU,
  input  logic [DW-1:0]  fIDEXrd,
  input  logic [RW-1:0]  fMux5,
  input  logic           jump_in,
  input  logic [DW-1:0]  jaddress_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WBW-1:0] Wb2,
  output logic           Branch,
  output logic           MemRead,
  output logic           MemWrite,
  output logic [DW-1:0]  tMux32,
  output logic           ZFtAND,
  output logic [DW-1:0]  AluRes,
  output logic [DW-1:0]  tWriteData,
  output logic [RW-1:0]  toMEMWB,
  output logic           jump_out,
  output logic [DW-1:0]  jaddress_out,
  output logic           redirect,
  output logic [DW-1:0]  redirect_pc,
  output logic [CW-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WBW-1:0] wb;
    logic           branch;
    logic           mem_read;
    logic           mem_write;
    logic [DW-1:0]  br_tgt;
    logic           zf;
    logic [DW-1:0]  alu;
    logic [DW-1:0]  st_data;
    logic [RW-1:0]  rd;
    logic           jump;
    logic [DW-1:0]  jaddr;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  entry_t        head_q, head_d, skid_q, skid_d, in_ent;
  logic [CW-1:0] stall_q, stall_d;
  logic          accept, pop;

  // Pack the incoming EX payload into one entry.
  always_comb begin
    in_ent           = '0;
    in_ent.wb        = WB2;
    in_ent.branch    = M2[0];
    in_ent.mem_read  = M2[1];
    in_ent.mem_write = M2[2];
    in_ent.br_tgt    = fAddR;
    in_ent.zf        = ZF;
    in_ent.alu       = fALU;
    in_ent.st_data   = fIDEXrd;
    in_ent.rd        = fMux5;
    in_ent.jump      = jump_in;
    in_ent.jaddr     = jaddress_in;
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clkEXMEM) begin
    if (rstEXMEM) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  // Occupancy next state; flush discards everything held.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !pop)      state_d = ST_FULL;
        else if (!accept && pop) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Handshake outputs decoded from state only, so in_ready has no path from out_ready.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
  end

  // Head/skid load selection; payload may go stale across a flush.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    unique case (state_q)
      ST_EMPTY: if (accept) head_d = in_ent;
      ST_ONE: begin
        if (accept && pop)       head_d = in_ent;
        else if (accept && !pop) skid_d = in_ent;
      end
      ST_FULL:  if (pop) head_d = skid_q;
      default:  ;
    endcase
  end

  // Back-pressure counter, saturating, cleared only by reset.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CW{1'b1}}))
      stall_d = stall_q + CW'(1);
  end

  // Payload and counter registers.
  always_ff @(posedge clkEXMEM) begin
    if (rstEXMEM) begin
      head_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Control fields read as a bubble when empty; data fields show the head register.
  assign Wb2          = out_valid ? head_q.wb : '0;
  assign Branch       = out_valid & head_q.branch;
  assign MemRead      = out_valid & head_q.mem_read;
  assign MemWrite     = out_valid & head_q.mem_write;
  assign jump_out     = out_valid & head_q.jump;
  assign tMux32       = head_q.br_tgt;
  assign ZFtAND       = head_q.zf;
  assign AluRes       = head_q.alu;
  assign tWriteData   = head_q.st_data;
  assign toMEMWB      = head_q.rd;
  assign jaddress_out = head_q.jaddr;
  assign stall_cnt    = stall_q;

  // Jump wins over a taken branch.
  assign redirect    = out_valid & (head_q.jump | (head_q.branch & head_q.zf));
  assign redirect_pc = jump_out ? head_q.jaddr : head_q.br_tgt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: queue-based reference model plus directed scenarios
// and randomized traffic; two instances differ only in stall counter width.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, ZF, jump_in;
  logic [1:0]  WB2;
  logic [2:0]  M2;
  logic [31:0] fAddR, fALU, fIDEXrd, jaddress_in;
  logic [4:0]  fMux5;

  logic        in_ready_a, out_valid_a, Branch_a, MemRead_a, MemWrite_a, ZFtAND_a, jump_out_a, redirect_a;
  logic [1:0]  Wb2_a;
  logic [31:0] tMux32_a, AluRes_a, tWriteData_a, jaddress_out_a, redirect_pc_a;
  logic [4:0]  toMEMWB_a;
  logic [15:0] stall_a;

  logic        in_ready_b, out_valid_b, Branch_b, MemRead_b, MemWrite_b, ZFtAND_b, jump_out_b, redirect_b;
  logic [1:0]  Wb2_b;
  logic [31:0] tMux32_b, AluRes_b, tWriteData_b, jaddress_out_b, redirect_pc_b;
  logic [4:0]  toMEMWB_b;
  logic [1:0]  stall_b;

  ex_mem_pipe dut_a (
    .clkEXMEM(clk), .rstEXMEM(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .WB2(WB2), .M2(M2), .fAddR(fAddR), .ZF(ZF), .fALU(fALU), .fIDEXrd(fIDEXrd), .fMux5(fMux5),
    .jump_in(jump_in), .jaddress_in(jaddress_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .Wb2(Wb2_a), .Branch(Branch_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a), .tMux32(tMux32_a),
    .ZFtAND(ZFtAND_a), .AluRes(AluRes_a), .tWriteData(tWriteData_a), .toMEMWB(toMEMWB_a),
    .jump_out(jump_out_a), .jaddress_out(jaddress_out_a), .redirect(redirect_a),
    .redirect_pc(redirect_pc_a), .stall_cnt(stall_a)
  );

  ex_mem_pipe #(.CW(2)) dut_b (
    .clkEXMEM(clk), .rstEXMEM(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .WB2(WB2), .M2(M2), .fAddR(fAddR), .ZF(ZF), .fALU(fALU), .fIDEXrd(fIDEXrd), .fMux5(fMux5),
    .jump_in(jump_in), .jaddress_in(jaddress_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .Wb2(Wb2_b), .Branch(Branch_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b), .tMux32(tMux32_b),
    .ZFtAND(ZFtAND_b), .AluRes(AluRes_b), .tWriteData(tWriteData_b), .toMEMWB(toMEMWB_b),
    .jump_out(jump_out_b), .jaddress_out(jaddress_out_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .stall_cnt(stall_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] addr;
    logic        zf;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        j;
    logic [31:0] ja;
  } ent_t;

  ent_t mq[$];
  int   ms16 = 0;
  int   ms2  = 0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries, updated at each rising edge.
  always @(posedge clk) begin
    bit   acc, pp;
    ent_t e;
    if (rst) begin
      mq.delete();
      ms16 = 0;
      ms2  = 0;
    end else begin
      if (mq.size() > 0 && !out_ready) begin
        if (ms16 < 65535) ms16++;
        if (ms2 < 3) ms2++;
      end
      if (flush) mq.delete();
      else begin
        acc = in_valid && (mq.size() < 2);
        pp  = (mq.size() > 0) && out_ready;
        e = '{wb: WB2, m: M2, addr: fAddR, zf: ZF, alu: fALU, wd: fIDEXrd,
              rd: fMux5, j: jump_in, ja: jaddress_in};
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
  end

  // Compare process: both instances against the model every cycle.
  always @(negedge clk) begin
    ent_t        h;
    logic [5:0]  ec;
    logic [133:0] ed;
    logic        er;
    logic [31:0] ep;
    if (chk_en) begin
      chk("out_valid_a", 160'(out_valid_a), 160'(mq.size() > 0));
      chk("out_valid_b", 160'(out_valid_b), 160'(mq.size() > 0));
      chk("in_ready_a", 160'(in_ready_a), 160'(mq.size() < 2));
      chk("in_ready_b", 160'(in_ready_b), 160'(mq.size() < 2));
      chk("stall_a", 160'(stall_a), 160'(ms16));
      chk("stall_b", 160'(stall_b), 160'(ms2));
      if (mq.size() > 0) begin
        h  = mq[0];
        ec = {h.wb, h.m[0], h.m[1], h.m[2], h.j};
        ed = {h.addr, h.zf, h.alu, h.wd, h.rd, h.ja};
        er = h.j || (h.m[0] && h.zf);
        ep = h.j ? h.ja : h.addr;
        chk("ctrl_a", 160'({Wb2_a, Branch_a, MemRead_a, MemWrite_a, jump_out_a}), 160'(ec));
        chk("ctrl_b", 160'({Wb2_b, Branch_b, MemRead_b, MemWrite_b, jump_out_b}), 160'(ec));
        chk("data_a", 160'({tMux32_a, ZFtAND_a, AluRes_a, tWriteData_a, toMEMWB_a, jaddress_out_a}), 160'(ed));
        chk("data_b", 160'({tMux32_b, ZFtAND_b, AluRes_b, tWriteData_b, toMEMWB_b, jaddress_out_b}), 160'(ed));
        chk("redirect_a", 160'(redirect_a), 160'(er));
        chk("redirect_b", 160'(redirect_b), 160'(er));
        chk("redirect_pc_a", 160'(redirect_pc_a), 160'(ep));
        chk("redirect_pc_b", 160'(redirect_pc_b), 160'(ep));
      end else begin
        chk("bubble_a", 160'({Wb2_a, Branch_a, MemRead_a, MemWrite_a, jump_out_a, redirect_a}), 160'(0));
        chk("bubble_b", 160'({Wb2_b, Branch_b, MemRead_b, MemWrite_b, jump_out_b, redirect_b}), 160'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; WB2 = 0; M2 = 0; fAddR = 0; ZF = 0;
    fALU = 0; fIDEXrd = 0; fMux5 = 0; jump_in = 0; jaddress_in = 0;
  endtask

  task automatic rand_payload();
    WB2 = 2'($urandom); M2 = 3'($urandom); fAddR = $urandom; ZF = 1'($urandom);
    fALU = $urandom; fIDEXrd = $urandom; fMux5 = 5'($urandom);
    jump_in = ($urandom_range(0, 3) == 0); jaddress_in = $urandom;
  endtask

  initial begin
    rst = 1; out_ready = 0;
    idle();
    tick();
    tick();
    chk_en = 1'b1;
    // Reset state
    chk("rst_out_valid", 160'(out_valid_a), 160'(0));
    chk("rst_in_ready", 160'(in_ready_a), 160'(1));
    chk("rst_payload", 160'({AluRes_a, tMux32_a, jaddress_out_a, toMEMWB_a, tWriteData_a}), 160'(0));
    chk("rst_stall", 160'(stall_a), 160'(0));

    // Single entry, one-cycle latency
    rst = 0;
    in_valid = 1; fALU = 32'h10; fMux5 = 5'd5; M2 = 3'b010; out_ready = 1;
    tick();
    chk("lat_valid", 160'(out_valid_a), 160'(1));
    chk("lat_alu", 160'(AluRes_a), 160'(32'h10));
    chk("lat_rd", 160'(toMEMWB_a), 160'(5));
    chk("lat_memread", 160'(MemRead_a), 160'(1));
    idle();
    tick();
    chk("drain_valid", 160'(out_valid_a), 160'(0));
    chk("drain_memread", 160'(MemRead_a), 160'(0));
    chk("drain_alu_hold", 160'(AluRes_a), 160'(32'h10));

    // Fill to FULL, third push ignored, ordered drain
    out_ready = 0; in_valid = 1; fALU = 32'd1;
    tick();
    fALU = 32'd2;
    tick();
    chk("full_in_ready", 160'(in_ready_a), 160'(0));
    fALU = 32'd3;
    tick();
    chk("full_head", 160'(AluRes_a), 160'(1));
    in_valid = 0; out_ready = 1;
    tick();
    chk("drain_second", 160'(AluRes_a), 160'(2));
    tick();
    chk("drain_empty", 160'(out_valid_a), 160'(0));

    // Redirect decode
    out_ready = 0; in_valid = 1; M2 = 3'b001; ZF = 1; fAddR = 32'h40; jump_in = 1; jaddress_in = 32'h80;
    tick();
    in_valid = 0;
    chk("jmp_redirect", 160'(redirect_a), 160'(1));
    chk("jmp_pc", 160'(redirect_pc_a), 160'(32'h80));
    in_valid = 1; out_ready = 1; jump_in = 0;
    tick();
    chk("br_redirect", 160'(redirect_a), 160'(1));
    chk("br_pc", 160'(redirect_pc_a), 160'(32'h40));
    ZF = 0;
    tick();
    chk("nt_redirect", 160'(redirect_a), 160'(0));
    idle();
    tick();

    // Flush while FULL
    out_ready = 0; in_valid = 1; M2 = 3'b101; fALU = 32'hA;
    tick();
    fALU = 32'hB;
    tick();
    chk("pre_flush_full", 160'(in_ready_a), 160'(0));
    flush = 1; fALU = 32'hC;
    tick();
    idle();
    chk("flush_valid", 160'(out_valid_a), 160'(0));
    chk("flush_in_ready", 160'(in_ready_a), 160'(1));
    chk("flush_ctrl", 160'({Branch_a, MemWrite_a}), 160'(0));
    out_ready = 1;
    tick();
    tick();
    chk("flush_no_emerge", 160'(out_valid_a), 160'(0));

    // Saturating stall counter on the narrow instance
    rst = 1;
    tick();
    rst = 0; out_ready = 0; in_valid = 1;
    tick();
    in_valid = 0;
    chk("stall_start", 160'(stall_b), 160'(0));
    tick(); chk("stall_1", 160'(stall_b), 160'(1));
    tick(); chk("stall_2", 160'(stall_b), 160'(2));
    tick(); chk("stall_3", 160'(stall_b), 160'(3));
    tick(); chk("stall_sat4", 160'(stall_b), 160'(3));
    tick(); chk("stall_sat5", 160'(stall_b), 160'(3));
    chk("stall_wide5", 160'(stall_a), 160'(5));
    rst = 1;
    tick();
    chk("stall_rst_b", 160'(stall_b), 160'(0));
    chk("stall_rst_a", 160'(stall_a), 160'(0));
    chk("rst_drop", 160'(out_valid_a), 160'(0));
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
